// File: rtl/combo_lock_param_if.sv
// Strobe/status bundle between the key front end and combo_lock_param.
// master drives the entry strobes; slave is the lock itself.
interface combo_lock_param_if #(
    parameter int DIGITS   = 6,
    parameter int DW       = 4,
    parameter int MAX_FAIL = 3
);
    logic                            digit_valid;
    logic [DW-1:0]                   digit;
    logic                            relock;
    logic                            prog;
    logic                            open;
    logic                            closed;
    logic                            locked_out;
    logic                            illegal;
    logic [$clog2(DIGITS+1)-1:0]     progress;
    logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;

    modport master (
        output digit_valid, digit, relock, prog,
        input  open, closed, locked_out, illegal, progress, fail_cnt
    );

    modport slave (
        input  digit_valid, digit, relock, prog,
        output open, closed, locked_out, illegal, progress, fail_cnt
    );
endinterface

// File: rtl/combo_lock_param.sv
// Parametrised combination lock with programmable code, fail counter and timed lockout.
// Optional inactivity timeout on partial entries is built when COMBO_TIMEOUT_EN is defined.
module combo_lock_param #(
    parameter int                     DIGITS       = 6,
    parameter int                     DW           = 4,
    parameter int                     MAX_DIGIT    = 9,
    parameter logic [DIGITS*DW-1:0]   DEFAULT_CODE = 24'h165963,
    parameter int                     MAX_FAIL     = 3,
    parameter int                     LOCKOUT_CYC  = 16,
    parameter int                     TIMEOUT_CYC  = 64
) (
    input logic               clk,
    input logic               reset,
    combo_lock_param_if.slave bus
);

    localparam int PW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam int CW = DIGITS * DW;

    if (DIGITS < 2) begin : g_chk_digits
        $error("combo_lock_param: DIGITS must be at least 2");
    end
    if (MAX_DIGIT > (1 << DW) - 1) begin : g_chk_max_digit
        $error("combo_lock_param: MAX_DIGIT does not fit in DW bits");
    end
    if (MAX_FAIL < 1 || LOCKOUT_CYC < 1 || TIMEOUT_CYC < 1) begin : g_chk_counts
        $error("combo_lock_param: MAX_FAIL, LOCKOUT_CYC and TIMEOUT_CYC must be positive");
    end

    typedef enum logic [2:0] {
        ENTRY,
        OPEN,
        CLOSED,
        LOCKOUT,
        PROG
    } state_t;

    state_t          state;
    logic [CW-1:0]   code;
    logic [CW-1:0]   staging;
    logic [CW-1:0]   staged_next;
    logic [PW-1:0]   progress;
    logic            mismatch;
    logic [FW-1:0]   fail_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            open_r;
    logic            closed_r;
    logic            locked_r;
    logic            illegal_r;

    logic [DW-1:0]   code_digit;
    logic            digit_illegal;
    logic            digit_bad;
    logic            last_digit;

`ifdef COMBO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   idle_cnt;
    logic            idle_run;
    logic            idle_hit;

    // Only a partially entered code in ENTRY is subject to the inactivity limit.
    assign idle_run = (state == ENTRY) && (progress != '0) && !bus.digit_valid;
    assign idle_hit = idle_run && (idle_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        code_digit    = code[int'(progress) * DW +: DW];
        digit_illegal = int'(bus.digit) > MAX_DIGIT;
        digit_bad     = digit_illegal || (bus.digit != code_digit);
        last_digit    = (progress == PW'(DIGITS - 1));
        staged_next   = staging;
        staged_next[int'(progress) * DW +: DW] = bus.digit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENTRY;
            code      <= DEFAULT_CODE;
            staging   <= '0;
            progress  <= '0;
            mismatch  <= 1'b0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            open_r    <= 1'b0;
            closed_r  <= 1'b0;
            locked_r  <= 1'b0;
            illegal_r <= 1'b0;
`ifdef COMBO_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            illegal_r <= 1'b0;
            case (state)
                ENTRY: begin
                    if (bus.digit_valid) begin
                        illegal_r <= digit_illegal;
                        if (last_digit) begin
                            progress <= '0;
                            mismatch <= 1'b0;
                            if (!(mismatch || digit_bad)) begin
                                state    <= OPEN;
                                open_r   <= 1'b1;
                                fail_cnt <= '0;
                            end else if (int'(fail_cnt) + 1 < MAX_FAIL) begin
                                state    <= CLOSED;
                                closed_r <= 1'b1;
                                fail_cnt <= fail_cnt + FW'(1);
                            end else begin
                                state    <= LOCKOUT;
                                locked_r <= 1'b1;
                                fail_cnt <= FW'(MAX_FAIL);
                                lock_cnt <= LW'(LOCKOUT_CYC);
                            end
                        end else begin
                            progress <= progress + PW'(1);
                            mismatch <= mismatch || digit_bad;
                        end
                    end
`ifdef COMBO_TIMEOUT_EN
                    else if (idle_hit) begin
                        progress <= '0;
                        mismatch <= 1'b0;
                    end
`endif
                end

                OPEN: begin
                    if (bus.relock) begin
                        state  <= ENTRY;
                        open_r <= 1'b0;
                    end else if (bus.prog) begin
                        state    <= PROG;
                        staging  <= '0;
                        progress <= '0;
                    end
                end

                CLOSED: begin
                    if (bus.relock) begin
                        state    <= ENTRY;
                        closed_r <= 1'b0;
                    end
                end

                // Exit is decided while the counter still reads 1 so the lockout lasts LOCKOUT_CYC cycles.
                LOCKOUT: begin
                    if (lock_cnt == LW'(1)) begin
                        state    <= ENTRY;
                        locked_r <= 1'b0;
                        fail_cnt <= '0;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end

                PROG: begin
                    if (bus.relock) begin
                        state    <= ENTRY;
                        open_r   <= 1'b0;
                        progress <= '0;
                    end else if (bus.digit_valid) begin
                        if (digit_illegal) begin
                            illegal_r <= 1'b1;
                            state     <= OPEN;
                            progress  <= '0;
                        end else if (last_digit) begin
                            staging  <= staged_next;
                            code     <= staged_next;
                            state    <= OPEN;
                            progress <= '0;
                        end else begin
                            staging  <= staged_next;
                            progress <= progress + PW'(1);
                        end
                    end
                end

                default: begin
                    state    <= ENTRY;
                    progress <= '0;
                    mismatch <= 1'b0;
                    open_r   <= 1'b0;
                    closed_r <= 1'b0;
                    locked_r <= 1'b0;
                end
            endcase

`ifdef COMBO_TIMEOUT_EN
            if (idle_run && !idle_hit) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

    assign bus.open       = open_r;
    assign bus.closed     = closed_r;
    assign bus.locked_out = locked_r;
    assign bus.illegal    = illegal_r;
    assign bus.progress   = progress;
    assign bus.fail_cnt   = fail_cnt;

endmodule
